// File: rtl/pc_stack_unit.sv
// Program counter with stall, jump, relative branch and call/return through a hardware return-address stack.
// Latency: one cycle from command strobe to registered pout; no combinational input-to-pout path.
// Backpressure: stall freezes pc, stack pointer, stack contents and flags for that cycle.
module pc_stack_unit #(
    parameter int              AW        = 6,
    parameter int              OFF_W     = 6,
    parameter int              DEPTH     = 4,
    parameter logic [AW-1:0]   RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       jump,
    input  logic                       branch,
    input  logic                       call,
    input  logic                       ret,
    input  logic [AW-1:0]              target,
    input  logic [OFF_W-1:0]           offset,
    output logic [AW-1:0]              pout,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stk_empty,
    output logic                       stk_full,
    output logic                       stk_ovf,
    output logic                       stk_unf
);

    localparam int SPW = $clog2(DEPTH+1);
    localparam int IW  = $clog2(DEPTH);

    localparam logic [AW-1:0]  PC_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_ONE = {{(SPW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

    logic [AW-1:0]  stack [DEPTH];
    logic [AW-1:0]  off_ext;
    logic [AW-1:0]  pc_inc;
    logic [AW-1:0]  pc_nxt;
    logic [SPW-1:0] sp_nxt;
    logic           push_en;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  top_idx;
    logic           ovf_set;
    logic           unf_set;

    // Offsets wider than the pc are truncated; narrower ones are sign-extended.
    if (OFF_W >= AW) begin : g_off_trunc
        assign off_ext = offset[AW-1:0];
    end else begin : g_off_sext
        assign off_ext = {{(AW-OFF_W){offset[OFF_W-1]}}, offset};
    end

    assign pc_inc    = pout + PC_ONE;
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == SP_MAX);

    // sp < DEPTH whenever push_idx is used and sp > 0 whenever top_idx is used,
    // so both fit the narrower index width.
    assign push_idx = IW'(sp);
    assign top_idx  = IW'(sp - SP_ONE);

    always_comb begin
        pc_nxt  = pc_inc;
        sp_nxt  = sp;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (stall) begin
            pc_nxt = pout;
        end else if (ret) begin
            if (stk_empty) begin
                unf_set = 1'b1;
            end else begin
                pc_nxt = stack[top_idx];
                sp_nxt = sp - SP_ONE;
            end
        end else if (call) begin
            pc_nxt = target;
            if (stk_full) begin
                ovf_set = 1'b1;
            end else begin
                push_en = 1'b1;
                sp_nxt  = sp + SP_ONE;
            end
        end else if (jump) begin
            pc_nxt = target;
        end else if (branch) begin
            pc_nxt = pout + off_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pout    <= RESET_VEC;
            sp      <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            pout    <= pc_nxt;
            sp      <= sp_nxt;
            stk_ovf <= stk_ovf | ovf_set;
            stk_unf <= stk_unf | unf_set;
        end
    end

    // Stack contents need no reset; sp alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit (AW=6, OFF_W=6, DEPTH=4, RESET_VEC=0).
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       jump = 1'b0;
    logic       branch = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [5:0] target = '0;
    logic [5:0] offset = '0;
    logic [5:0] pout;
    logic [2:0] sp;
    logic       stk_empty;
    logic       stk_full;
    logic       stk_ovf;
    logic       stk_unf;

    int total = 0;
    int bad   = 0;

    pc_stack_unit #(.AW(6), .OFF_W(6), .DEPTH(4), .RESET_VEC(6'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jump      (jump),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .offset    (offset),
        .pout      (pout),
        .sp        (sp),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of strobes, clock it, and sample 1 time unit after the edge.
    task automatic drive(input logic r, input logic s, input logic rt, input logic c,
                         input logic j, input logic b, input logic [5:0] t, input logic [5:0] o);
        rst = r; stall = s; ret = rt; call = c; jump = j; branch = b; target = t; offset = o;
        @(posedge clk);
        #1;
        rst = 1'b0; stall = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0; branch = 1'b0;
    endtask

    task automatic do_rst();                 drive(1, 0, 0, 0, 0, 0, 6'd0, 6'd0); endtask
    task automatic do_idle();                drive(0, 0, 0, 0, 0, 0, 6'd0, 6'd0); endtask
    task automatic do_stall();               drive(0, 1, 0, 0, 0, 0, 6'd0, 6'd0); endtask
    task automatic do_jump(input logic [5:0] t);   drive(0, 0, 0, 0, 1, 0, t, 6'd0); endtask
    task automatic do_branch(input logic [5:0] o); drive(0, 0, 0, 0, 0, 1, 6'd0, o); endtask
    task automatic do_call(input logic [5:0] t);   drive(0, 0, 0, 1, 0, 0, t, 6'd0); endtask
    task automatic do_ret();                 drive(0, 0, 1, 0, 0, 0, 6'd0, 6'd0); endtask

    initial begin
        // Reset and free-running wrap
        do_rst();
        chk("rst_pout", 32'(pout), 0);
        chk("rst_sp", 32'(sp), 0);
        chk("rst_ovf", 32'(stk_ovf), 0);
        chk("rst_unf", 32'(stk_unf), 0);
        chk("rst_empty", 32'(stk_empty), 1);
        chk("rst_full", 32'(stk_full), 0);
        for (int i = 1; i <= 70; i++) begin
            do_idle();
            chk($sformatf("inc_pout_%0d", i), 32'(pout), 32'(i % 64));
            chk($sformatf("inc_empty_%0d", i), 32'(stk_empty), 1);
        end
        chk("inc_pout_after70", 32'(pout), 6);

        // Stall, jump, branch
        do_jump(6'd10);
        chk("jump10", 32'(pout), 10);
        for (int i = 0; i < 3; i++) begin
            do_stall();
            chk($sformatf("stall_%0d", i), 32'(pout), 10);
        end
        drive(0, 1, 0, 1, 1, 0, 6'd33, 6'd0);
        chk("stall_beats_call_pout", 32'(pout), 10);
        chk("stall_beats_call_sp", 32'(sp), 0);
        do_jump(6'd40);
        chk("jump40", 32'(pout), 40);
        do_branch(6'b111100);
        chk("branch_m4", 32'(pout), 36);
        do_branch(6'd5);
        chk("branch_p5", 32'(pout), 41);
        drive(0, 0, 0, 0, 1, 1, 6'd12, 6'd5);
        chk("jump_beats_branch", 32'(pout), 12);

        // Nested call/ret
        do_jump(6'd5);
        chk("nest_start", 32'(pout), 5);
        do_call(6'd20);
        chk("nest_call1_pout", 32'(pout), 20);
        chk("nest_call1_sp", 32'(sp), 1);
        do_idle();
        chk("nest_idle1", 32'(pout), 21);
        do_idle();
        chk("nest_idle2", 32'(pout), 22);
        do_call(6'd50);
        chk("nest_call2_pout", 32'(pout), 50);
        chk("nest_call2_sp", 32'(sp), 2);
        do_ret();
        chk("nest_ret1_pout", 32'(pout), 23);
        chk("nest_ret1_sp", 32'(sp), 1);
        do_ret();
        chk("nest_ret2_pout", 32'(pout), 6);
        chk("nest_ret2_sp", 32'(sp), 0);

        // Overflow and underflow
        do_rst();
        for (int k = 1; k <= 5; k++) begin
            do_call(6'd8);
            chk($sformatf("ovf_call%0d_pout", k), 32'(pout), 8);
            chk($sformatf("ovf_call%0d_sp", k), 32'(sp), (k > 4) ? 4 : k);
            chk($sformatf("ovf_call%0d_full", k), 32'(stk_full), (k >= 4) ? 1 : 0);
            chk($sformatf("ovf_call%0d_flag", k), 32'(stk_ovf), (k == 5) ? 1 : 0);
        end
        for (int k = 1; k <= 4; k++) begin
            do_ret();
            chk($sformatf("ovf_ret%0d_pout", k), 32'(pout), (k == 4) ? 1 : 9);
            chk($sformatf("ovf_ret%0d_sp", k), 32'(sp), 4 - k);
            chk($sformatf("ovf_ret%0d_flag", k), 32'(stk_ovf), 1);
            chk($sformatf("ovf_ret%0d_unf", k), 32'(stk_unf), 0);
        end
        do_ret();
        chk("unf_ret_pout", 32'(pout), 2);
        chk("unf_ret_flag", 32'(stk_unf), 1);
        chk("unf_ret_sp", 32'(sp), 0);
        chk("unf_ret_empty", 32'(stk_empty), 1);
        do_idle();
        chk("sticky_pout", 32'(pout), 3);
        chk("sticky_ovf", 32'(stk_ovf), 1);
        chk("sticky_unf", 32'(stk_unf), 1);
        do_branch(6'b111100);
        chk("branch_wrap", 32'(pout), 63);

        // Simultaneous strobes: ret wins, call must not push
        do_rst();
        do_jump(6'd29);
        do_call(6'd45);
        chk("simul_setup_pout", 32'(pout), 45);
        chk("simul_setup_sp", 32'(sp), 1);
        drive(0, 0, 1, 1, 1, 0, 6'd60, 6'd0);
        chk("simul_pout", 32'(pout), 30);
        chk("simul_sp", 32'(sp), 0);
        chk("simul_ovf", 32'(stk_ovf), 0);
        do_ret();
        chk("simul_nopush_pout", 32'(pout), 31);
        chk("simul_nopush_unf", 32'(stk_unf), 1);

        // Reset together with call mid-operation
        do_rst();
        for (int k = 0; k < 5; k++) do_call(6'd8);
        do_ret();
        chk("midrst_setup_sp", 32'(sp), 3);
        chk("midrst_setup_ovf", 32'(stk_ovf), 1);
        drive(1, 0, 0, 1, 0, 0, 6'd50, 6'd0);
        chk("midrst_pout", 32'(pout), 0);
        chk("midrst_sp", 32'(sp), 0);
        chk("midrst_ovf", 32'(stk_ovf), 0);
        chk("midrst_unf", 32'(stk_unf), 0);
        do_idle();
        chk("midrst_inc", 32'(pout), 1);
        do_ret();
        chk("midrst_nopush_pout", 32'(pout), 2);
        chk("midrst_nopush_unf", 32'(stk_unf), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter for the CPU fetch stage; drives the instruction-memory address `pout` every cycle.
- Adds what a free-running counter lacks:
  - stall
  - absolute jump
  - signed relative branch
  - call/return via an internal hardware return-address stack
  - stack status and sticky error flags
- Sits between the control unit, which issues the command strobes, and instruction memory.

Parameters:
AW, 6, address width of `pout` and all address operands
OFF_W, 6, width of the signed relative branch offset
DEPTH, 4, return-stack entries (>=2)
RESET_VEC, 0, value loaded into `pout` on reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall  in  1  hold pc and stack unchanged this cycle
jump  in  1  load `pout` <= `target`
branch  in  1  `pout` <= `pout` + sign-extended `offset`
call  in  1  push `pout`+1, then `pout` <= `target`
ret  in  1  pop top-of-stack into `pout`
target  in  AW  absolute destination for jump/call
offset  in  OFF_W  two's-complement branch offset
pout  out  AW  current program counter (registered)
sp  out  $clog2(DEPTH+1)  number of valid stack entries
stk_empty  out  1  `sp`==0 (combinational from `sp`)
stk_full  out  1  `sp`==DEPTH (combinational from `sp`)
stk_ovf  out  1  sticky: call issued while full
stk_unf  out  1  sticky: ret issued while empty

Behaviour:
- Clocking and reset:
  - One clock (`clk`). Reset is synchronous and active-high (`rst`).
  - All state updates on the rising edge of `clk`.
- Reset (highest priority, sampled at the edge):
  - `pout` = RESET_VEC, `sp` = 0, `stk_ovf` = 0, `stk_unf` = 0.
  - Stack contents are don't-care.
  - Reset asserted mid-sequence (e.g. during a call chain) discards all pending state in the same edge.
- Command priority per cycle: rst > stall > ret > call > jump > branch > increment.
  - Lower-priority strobes asserted in the same cycle are ignored entirely: no side effects, no flag updates.
- Latency: one cycle. The command sampled at edge N is reflected on `pout` after edge N. No combinational path from inputs to `pout`.
- stall: `pout`, `sp`, stack and flags hold.
- increment (no strobe): `pout` <= `pout`+1 modulo 2^AW. All-ones wraps to 0.
- jump: `pout` <= `target`.
- branch:
  - `pout` <= (`pout` + sign_extend(`offset`, AW)) modulo 2^AW.
  - Offset is relative to the current `pout`, not `pout`+1.
  - If OFF_W > AW, `offset` is truncated to AW bits before the add.
- call, not full:
  - stack[`sp`] <= (`pout`+1) mod 2^AW; `sp` <= `sp`+1; `pout` <= `target`.
- call, full:
  - `pout` <= `target`.
  - Push dropped; `sp` and entries unchanged.
  - `stk_ovf` <= 1.
- ret, not empty: `pout` <= stack[`sp`-1]; `sp` <= `sp`-1.
- ret, empty:
  - Treated as increment: `pout` <= `pout`+1.
  - `stk_unf` <= 1.
  - `sp` stays 0.
- Sticky flags: cleared only by `rst`.
- Stack implementation: a register array indexed by `sp`. LIFO ordering is required.

Test Plan:
- Reset/increment wrap, AW=6, RESET_VEC=0:
  - Stimulus: assert `rst` one edge, then 70 idle edges.
  - Required: `pout` = 0 after reset; counts 1..63; 0 at edge 64; `pout` = 6 after edge 70; `stk_empty` = 1 throughout.
- Stall/jump/branch:
  - Stimulus: from `pout` = 10:
    - stall 3 edges;
    - jump `target`=40;
    - branch `offset`=6'b111100 (-4);
    - branch `offset`=5.
  - Required: `pout` stays 10 for 3 edges, then 40, then 36, then 41.
- Nested call/ret:
  - Stimulus: from `pout` = 5:
    - call `target`=20;
    - 2 idle edges;
    - call `target`=50;
    - ret;
    - ret.
  - Required:
    - `pout` = 20 with `sp`=1;
    - then 21, 22;
    - then 50 with `sp`=2;
    - then 23 with `sp`=1;
    - then 6 with `sp`=0.
- Overflow/underflow, DEPTH=4:
  - Stimulus: 5 consecutive calls to `target`=8, then 5 rets.
  - Required:
    - `stk_full` = 1 after the 4th call;
    - 5th call gives `pout` = 8 with `stk_ovf` = 1 and `sp` = 4;
    - rets return 9, 9, 9, 1 with `sp` reaching 0;
    - 5th ret gives `pout` = 2 with `stk_unf` = 1;
    - both flags stay high until `rst`.
- Simultaneous strobes:
  - Stimulus: `ret`+`call`+`jump` asserted together with `sp`=1 (top = 30).
  - Required: `pout` = 30 and `sp` = 0; the call does not push.
- Reset mid-operation:
  - Stimulus: `sp`=3, `stk_ovf`=1, assert `rst` together with `call`.
  - Required: `pout` = RESET_VEC, `sp` = 0, flags cleared, no push.
